// File: rtl/train_ctrl_pkg.sv
// Shared types and constants for the training-array phase sequencer and its decode.
package train_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE = 2'b00,
    PH_FP   = 2'b01,
    PH_BP   = 2'b10,
    PH_WG   = 2'b11
  } phase_e;

  localparam logic [1:0] MODE_FIRST_S2 = 2'b00;
  localparam logic [1:0] MODE_FIRST_S1 = 2'b01;
  localparam logic [1:0] MODE_CUT_S2   = 2'b10;
  localparam logic [1:0] MODE_CUT_S1   = 2'b11;

  localparam logic [2:0] OMODE_PASS  = 3'b000;
  localparam logic [2:0] OMODE_WG_S1 = 3'b001;
  localparam logic [2:0] OMODE_FP_S2 = 3'b010;
  localparam logic [2:0] OMODE_WG_S2 = 3'b011;
  localparam logic [2:0] OMODE_BP_S2 = 3'b100;

  typedef struct packed {
    logic       select_m0;
    logic       select_m1;
    logic       select_m2;
    logic       select_m3;
    logic       select0;
    logic       select1;
    logic       en_cutting0;
    logic       en_cutting1;
    logic [1:0] mode;
    logic [2:0] omode;
    logic       buf_in;
    logic       buf_out;
  } sel_t;

  // Lowest enabled phase strictly after cur; PH_NONE when the sequence is exhausted.
  function automatic phase_e next_phase(input logic [2:0] en, input phase_e cur);
    phase_e nxt;
    nxt = PH_NONE;
    for (int i = 3; i >= 1; i--)
      if (en[i-1] && (i > int'(cur))) nxt = phase_e'(2'(i));
    return nxt;
  endfunction

endpackage

// File: rtl/phase_decode.sv
// Combinational decode of (state, phase, stride) into array mux selects and prefetch modes.
module phase_decode
  import train_ctrl_pkg::*;
(
  input  state_e     state,
  input  phase_e     phase,
  input  logic       stride_q,
  output logic       in_en,
  output logic       out_en,
  output logic       pe_rst_n,
  output sel_t       sel
);

  always_comb begin
    in_en    = (state == ST_FEED);
    out_en   = (state == ST_DRAIN);
    pe_rst_n = (state == ST_FEED) || (state == ST_DRAIN);

    sel       = '0;
    sel.mode  = MODE_FIRST_S1;
    sel.omode = OMODE_PASS;
    if (state != ST_IDLE) begin
      unique case (phase)
        PH_FP: begin
          sel.select1     = 1'b1;
          sel.en_cutting0 = 1'b1;
          sel.buf_in      = 1'b1;
          sel.select_m0   = stride_q;
          sel.select_m1   = stride_q;
          sel.mode        = stride_q ? MODE_FIRST_S2 : MODE_FIRST_S1;
          sel.omode       = stride_q ? OMODE_FP_S2 : OMODE_PASS;
        end
        PH_BP: begin
          sel.buf_out     = 1'b1;
          sel.select1     = !stride_q;
          sel.en_cutting1 = stride_q;
          sel.mode        = stride_q ? MODE_CUT_S2 : MODE_CUT_S1;
          sel.omode       = stride_q ? OMODE_BP_S2 : OMODE_PASS;
        end
        PH_WG: begin
          sel.select_m2 = 1'b1;
          sel.select_m3 = 1'b1;
          sel.select0   = 1'b1;
          sel.select_m0 = stride_q;
          sel.select_m1 = stride_q;
          sel.mode      = stride_q ? MODE_CUT_S2 : MODE_CUT_S1;
          sel.omode     = stride_q ? OMODE_WG_S2 : OMODE_WG_S1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/train_phase_seq.sv
// FP/BP/WG phase sequencer: walks enabled phases over N layers through FEED/DRAIN/CLEAR.
module train_phase_seq
  import train_ctrl_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int LAYER_W = 4
) (
  input  logic               clk,
  input  logic               fsm_rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [2:0]         phase_en,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic [CNT_W-1:0]   in_len,
  input  logic [CNT_W-1:0]   out_len,
  input  logic [CNT_W-1:0]   rst_len,
  input  logic               stride,
  output logic               busy,
  output logic               done,
  output logic [1:0]         phase,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               in_en,
  output logic               out_en,
  output logic               pe_rst_n,
  output logic               select_m0,
  output logic               select_m1,
  output logic               select_m2,
  output logic               select_m3,
  output logic               select0,
  output logic               select1,
  output logic               en_cutting0,
  output logic               en_cutting1,
  output logic [1:0]         inpref_mode_selector,
  output logic [2:0]         inpref_mode_selector_output,
  output logic               buf_input_select,
  output logic               buf_output_select
);

  state_e             state, state_d;
  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [LAYER_W-1:0] layer, layer_d;
  logic               stride_q, stride_d;
  logic               done_q, done_d;
  logic               load;

  logic [2:0]         en_q;
  logic [LAYER_W-1:0] nl_q;
  logic [CNT_W-1:0]   in_q, out_q, rst_q;

  // Zero-length FEED/CLEAR and zero layers behave as length one.
  logic [CNT_W-1:0]   in_last, out_last, rst_last;
  logic [LAYER_W-1:0] nl_last, nl_in_last;
  logic               layer_last;
  phase_e             first_ph, next_ph;

  assign in_last    = (in_q == '0) ? '0 : in_q - 1'b1;
  assign out_last   = out_q - 1'b1;
  assign rst_last   = (rst_q == '0) ? '0 : rst_q - 1'b1;
  assign nl_last    = (nl_q == '0) ? '0 : nl_q - 1'b1;
  assign nl_in_last = (num_layers == '0) ? '0 : num_layers - 1'b1;
  assign layer_last = (phase_q == PH_FP) ? (layer == nl_last) : (layer == '0);
  assign first_ph   = next_phase(phase_en, PH_NONE);
  assign next_ph    = next_phase(en_q, phase_q);

  always_comb begin
    state_d  = state;
    phase_d  = phase_q;
    cnt_d    = cnt;
    layer_d  = layer;
    stride_d = stride_q;
    done_d   = 1'b0;
    load     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          if (phase_en != 3'b000) begin
            load     = 1'b1;
            state_d  = ST_FEED;
            phase_d  = first_ph;
            layer_d  = (first_ph == PH_FP) ? '0 : nl_in_last;
            cnt_d    = '0;
            stride_d = stride;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (cnt == in_last) begin
          cnt_d   = '0;
          state_d = (out_q == '0) ? ST_CLEAR : ST_DRAIN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (cnt == out_last) begin
          cnt_d   = '0;
          state_d = ST_CLEAR;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (cnt == rst_last) begin
          cnt_d = '0;
          if (!layer_last) begin
            layer_d  = (phase_q == PH_FP) ? layer + 1'b1 : layer - 1'b1;
            state_d  = ST_FEED;
            stride_d = stride;
          end else if (next_ph != PH_NONE) begin
            phase_d  = next_ph;
            layer_d  = (next_ph == PH_FP) ? '0 : nl_last;
            state_d  = ST_FEED;
            stride_d = stride;
          end else begin
            phase_d = PH_NONE;
            layer_d = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a completing CLEAR.
    if (abort && (state != ST_IDLE)) begin
      state_d = ST_IDLE;
      phase_d = PH_NONE;
      cnt_d   = '0;
      layer_d = '0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge fsm_rst_n) begin
    if (!fsm_rst_n) begin
      state    <= ST_IDLE;
      phase_q  <= PH_NONE;
      cnt      <= '0;
      layer    <= '0;
      stride_q <= 1'b0;
      done_q   <= 1'b0;
      en_q     <= '0;
      nl_q     <= '0;
      in_q     <= '0;
      out_q    <= '0;
      rst_q    <= '0;
    end else begin
      state    <= state_d;
      phase_q  <= phase_d;
      cnt      <= cnt_d;
      layer    <= layer_d;
      stride_q <= stride_d;
      done_q   <= done_d;
      if (load) begin
        en_q  <= phase_en;
        nl_q  <= num_layers;
        in_q  <= in_len;
        out_q <= out_len;
        rst_q <= rst_len;
      end
    end
  end

  sel_t sel;

  phase_decode u_dec (
    .state    (state),
    .phase    (phase_q),
    .stride_q (stride_q),
    .in_en    (in_en),
    .out_en   (out_en),
    .pe_rst_n (pe_rst_n),
    .sel      (sel)
  );

  assign busy                        = (state != ST_IDLE);
  assign done                        = done_q;
  assign phase                       = phase_q;
  assign layer_idx                   = layer;
  assign select_m0                   = sel.select_m0;
  assign select_m1                   = sel.select_m1;
  assign select_m2                   = sel.select_m2;
  assign select_m3                   = sel.select_m3;
  assign select0                     = sel.select0;
  assign select1                     = sel.select1;
  assign en_cutting0                 = sel.en_cutting0;
  assign en_cutting1                 = sel.en_cutting1;
  assign inpref_mode_selector        = sel.mode;
  assign inpref_mode_selector_output = sel.omode;
  assign buf_input_select            = sel.buf_in;
  assign buf_output_select           = sel.buf_out;

endmodule

// File: tb/tb_train_phase_seq.sv
// Scoreboard bench: a run builds the whole expected per-cycle trace; a negedge monitor checks it.
module tb_train_phase_seq;

  logic       clk = 1'b0;
  logic       fsm_rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, stride = 1'b0;
  logic [2:0] phase_en = '0;
  logic [3:0] num_layers = '0;
  logic [7:0] in_len = '0, out_len = '0, rst_len = '0;
  logic       busy, done, in_en, out_en, pe_rst_n;
  logic [1:0] phase, inpref_mode_selector;
  logic [3:0] layer_idx;
  logic [2:0] inpref_mode_selector_output;
  logic select_m0, select_m1, select_m2, select_m3, select0, select1;
  logic en_cutting0, en_cutting1, buf_input_select, buf_output_select;

  always #5 clk = ~clk;

  train_phase_seq #(.CNT_W(8), .LAYER_W(4)) dut (
    .clk(clk), .fsm_rst_n(fsm_rst_n), .start(start), .abort(abort),
    .phase_en(phase_en), .num_layers(num_layers), .in_len(in_len),
    .out_len(out_len), .rst_len(rst_len), .stride(stride),
    .busy(busy), .done(done), .phase(phase), .layer_idx(layer_idx),
    .in_en(in_en), .out_en(out_en), .pe_rst_n(pe_rst_n),
    .select_m0(select_m0), .select_m1(select_m1), .select_m2(select_m2),
    .select_m3(select_m3), .select0(select0), .select1(select1),
    .en_cutting0(en_cutting0), .en_cutting1(en_cutting1),
    .inpref_mode_selector(inpref_mode_selector),
    .inpref_mode_selector_output(inpref_mode_selector_output),
    .buf_input_select(buf_input_select), .buf_output_select(buf_output_select)
  );

  typedef struct packed {
    logic       busy, done;
    logic [1:0] phase;
    logic [3:0] layer;
    logic       in_en, out_en, pe_rst_n;
    logic [14:0] dec;
  } snap_t;

  snap_t exp_q[$];
  logic  ssched[0:1023];
  int    n_cmp = 0, n_bad = 0;

  // Decode truth table: {m0,m1,m2,m3,sel0,sel1,cut0,cut1,mode,omode,buf_in,buf_out}.
  function automatic logic [14:0] dtab(input logic [1:0] ph, input logic s);
    case ({ph, s})
      3'b010:  return 15'b0000_01_10_01_000_10;
      3'b011:  return 15'b1100_01_10_00_010_10;
      3'b100:  return 15'b0000_01_00_11_000_01;
      3'b101:  return 15'b0000_00_01_10_100_01;
      3'b110:  return 15'b0011_10_00_11_001_00;
      3'b111:  return 15'b1111_10_00_10_011_00;
      default: return 15'b0000_00_00_01_000_00;
    endcase
  endfunction

  // st: 0 idle, 1 feed, 2 drain, 3 clear
  function automatic snap_t mk(input logic dn, input logic [1:0] ph, input logic [3:0] l,
                               input int st, input logic s);
    snap_t r;
    r.busy     = (st != 0);
    r.done     = dn;
    r.phase    = (st == 0) ? 2'b00 : ph;
    r.layer    = (st == 0) ? 4'd0 : l;
    r.in_en    = (st == 1);
    r.out_en   = (st == 2);
    r.pe_rst_n = (st == 1) || (st == 2);
    r.dec      = dtab(r.phase, s);
    return r;
  endfunction

  function automatic snap_t sample();
    snap_t r;
    r.busy = busy; r.done = done; r.phase = phase; r.layer = layer_idx;
    r.in_en = in_en; r.out_en = out_en; r.pe_rst_n = pe_rst_n;
    r.dec = {select_m0, select_m1, select_m2, select_m3, select0, select1,
             en_cutting0, en_cutting1, inpref_mode_selector,
             inpref_mode_selector_output, buf_input_select, buf_output_select};
    return r;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e, a;
      e = exp_q.pop_front();
      a = sample();
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_snapshot t=%0t got=%h expected=%h", $time, a, e);
      end
    end
  end

  // Offset 0 is the start cycle; ka = abort offset, kr = reset offset, ksb = start-while-busy offset.
  task automatic run(input logic [2:0] pe, input logic [3:0] nl, input logic [7:0] il,
                     input logic [7:0] ol, input logic [7:0] rl,
                     input int ka, input int kr, input int ksb);
    snap_t tr[$];
    snap_t full[$];
    int n, fl, rlen, lay;
    full.push_back(mk(1'b0, 2'b00, 4'd0, 0, 1'b0));
    if (pe == 3'b000) begin
      full.push_back(mk(1'b1, 2'b00, 4'd0, 0, 1'b0));
    end else begin
      n    = (nl == 0) ? 1 : int'(nl);
      fl   = (il == 0) ? 1 : int'(il);
      rlen = (rl == 0) ? 1 : int'(rl);
      for (int p = 1; p <= 3; p++) begin
        if (pe[p-1]) begin
          for (int i = 0; i < n; i++) begin
            logic s;
            lay = (p == 1) ? i : n - 1 - i;
            s   = ssched[full.size() - 1];
            for (int c = 0; c < fl; c++)   full.push_back(mk(1'b0, 2'(p), 4'(lay), 1, s));
            for (int c = 0; c < ol; c++)   full.push_back(mk(1'b0, 2'(p), 4'(lay), 2, s));
            for (int c = 0; c < rlen; c++) full.push_back(mk(1'b0, 2'(p), 4'(lay), 3, s));
          end
        end
      end
      full.push_back(mk(1'b1, 2'b00, 4'd0, 0, 1'b0));
    end
    full.push_back(mk(1'b0, 2'b00, 4'd0, 0, 1'b0));

    if (ka > 0 && ka < full.size() && full[ka].busy) begin
      for (int k = 0; k <= ka; k++) tr.push_back(full[k]);
      repeat (2) tr.push_back(mk(1'b0, 2'b00, 4'd0, 0, 1'b0));
    end else if (kr > 0 && kr < full.size()) begin
      for (int k = 0; k < kr; k++) tr.push_back(full[k]);
      repeat (3) tr.push_back(mk(1'b0, 2'b00, 4'd0, 0, 1'b0));
    end else begin
      tr = full;
      ka = -1;
      kr = -1;
    end
    if (ksb > 0 && (ksb >= tr.size() || !tr[ksb].busy)) ksb = -1;

    @(posedge clk); #1;
    foreach (tr[k]) exp_q.push_back(tr[k]);
    for (int off = 0; off < tr.size(); off++) begin
      start     = (off == 0) || (off == ksb);
      abort     = (off == ka);
      fsm_rst_n = !(off == kr);
      stride    = ssched[off];
      if (off == 0) begin
        phase_en = pe; num_layers = nl; in_len = il; out_len = ol; rst_len = rl;
      end else begin
        phase_en = 3'($urandom); num_layers = 4'($urandom);
        in_len = 8'($urandom); out_len = 8'($urandom); rst_len = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; fsm_rst_n = 1'b1;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout left=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_stride(input int mode); // 0 all zero, 1 all one, 2 random
    for (int i = 0; i < 1024; i++)
      ssched[i] = (mode == 2) ? 1'($urandom) : (mode == 1);
  endtask

  initial begin
    repeat (3) exp_q.push_back(mk(1'b0, 2'b00, 4'd0, 0, 1'b0));
    repeat (3) @(posedge clk);
    #1 fsm_rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_stride(0);
    run(3'b001, 4'd1, 8'd8, 8'd5, 8'd1, -1, -1, -1);
    run(3'b111, 4'd2, 8'd2, 8'd1, 8'd2, -1, -1, -1);
    set_stride(1);
    run(3'b111, 4'd2, 8'd2, 8'd1, 8'd2, -1, -1, -1);
    set_stride(2);
    run(3'b111, 4'd2, 8'd2, 8'd1, 8'd2, -1, -1, -1);
    set_stride(0);
    run(3'b001, 4'd1, 8'd8, 8'd5, 8'd1, 11, -1, -1);
    run(3'b001, 4'd0, 8'd0, 8'd0, 8'd0, -1, -1, -1);
    run(3'b000, 4'd3, 8'd2, 8'd2, 8'd2, -1, -1, -1);
    set_stride(2);
    run(3'b111, 4'd2, 8'd2, 8'd1, 8'd2, -1, 2, 1);
    run(3'b111, 4'd2, 8'd2, 8'd1, 8'd2, -1, -1, 5);
    run(3'b110, 4'd3, 8'd1, 8'd0, 8'd1, -1, -1, -1);

    for (int r = 0; r < 30; r++) begin
      int ka, kr, ksb;
      set_stride(2);
      ka  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
      kr  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 40)) : -1;
      ksb = int'($urandom_range(1, 30));
      run(3'($urandom), 4'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
          8'($urandom_range(0, 2)), 8'($urandom_range(0, 2)), ka, kr, ksb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/train_phase_seq.md
Name: train_phase_seq

Overview:
- Parametrised successor to the single-pass FP/BP/WG controller of the training systolic array.
- Sequences up to three enabled phases (FP, BP, WG) over N layers with runtime-programmable feed, drain and PE-clear lengths.
- Drives the array muxes, the input prefetcher and the output buffer, with a start/busy/done/abort handshake to the host sequencer.
- Sits between the host control registers and the PE array / input-prefetch / output-buffer datapath.

Parameters:
- CNT_W, 8, width of in_len / out_len / rst_len and their internal counters.
- LAYER_W, 4, width of num_layers and layer_idx.

Ports:
- clk  in  1  clock
- fsm_rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sequence; accepted only in IDLE
- abort  in  1  synchronous abort
- phase_en  in  3  bit0=FP, bit1=BP, bit2=WG
- num_layers  in  LAYER_W  layers per phase; 0 is treated as 1
- in_len  in  CNT_W  FEED cycles; 0 is treated as 1
- out_len  in  CNT_W  DRAIN cycles; 0 skips DRAIN
- rst_len  in  CNT_W  CLEAR cycles; 0 is treated as 1
- stride  in  1  0 = stride 1, 1 = stride 2; sampled on every FEED entry
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- phase  out  2  00 none, 01 FP, 10 BP, 11 WG
- layer_idx  out  LAYER_W  current layer
- in_en, out_en, pe_rst_n  out  1  array feed enable, output enable, active-low PE clear
- select_m0, select_m1, select_m2, select_m3, select0, select1  out  1  array mux selects
- en_cutting0, en_cutting1  out  1  input cutting enables
- inpref_mode_selector  out  2  input prefetcher mode
- inpref_mode_selector_output  out  3  input prefetcher output mode
- buf_input_select, buf_output_select  out  1  output buffer routing

Behaviour:

Configuration capture
- phase_en, num_layers, in_len, out_len and rst_len are latched when start is accepted.
- stride is latched into stride_q on each FEED entry.

States and transitions: IDLE, FEED, DRAIN, CLEAR (Moore). Cycle counter cnt; layer counter.
- IDLE: start=1, abort=0 and phase_en!=0 -> FEED of the lowest enabled phase, from the next cycle.
- IDLE: start with phase_en==0 -> stay IDLE; done pulses the next cycle.
- FEED: lasts max(in_len,1) cycles -> DRAIN, or CLEAR if out_len==0.
- DRAIN: lasts out_len cycles -> CLEAR.
- CLEAR: lasts max(rst_len,1) cycles, then one of:
  - next layer, FEED;
  - if the layer was the last, first layer of the next enabled phase, FEED;
  - if the phase was also the last, IDLE with done=1 for exactly that first IDLE cycle.

Layer order
- FP: ascending 0..N-1.
- BP and WG: descending N-1..0.
- layer_idx = 0 in IDLE.

abort and start handling
- abort=1 in any non-IDLE state -> IDLE next cycle, counters cleared, no done.
- abort beats start in the same cycle.
- start while busy is ignored.

Per-state outputs
- in_en=1 only in FEED.
- out_en=1 only in DRAIN.
- pe_rst_n=0 in IDLE and CLEAR, 1 in FEED and DRAIN.
- All outputs are combinational decodes of registered state, phase and stride_q.

Decode (s = stride_q)
- IDLE (also the reset values):
  - all selects, en_cutting and buf selects = 0, busy = 0, done = 0, phase = 00;
  - inpref_mode_selector = 01, inpref_mode_selector_output = 000.
- FP:
  - select_m2 = select_m3 = 0, select0 = 0, select1 = 1, en_cutting0 = 1, buf_input_select = 1;
  - s=0: select_m0 = select_m1 = 0, mode 01/000;
  - s=1: select_m0 = select_m1 = 1, mode 00/010.
- BP:
  - select_m0..select_m3 = 0, select0 = 0, buf_output_select = 1;
  - s=0: select1 = 1, mode 11/000;
  - s=1: select1 = 0, en_cutting1 = 1, mode 10/100.
- WG:
  - select_m2 = select_m3 = 1, select0 = 1, select1 = 0;
  - s=0: select_m0 = select_m1 = 0, mode 11/001;
  - s=1: select_m0 = select_m1 = 1, mode 10/011.
- Any signal not listed for a phase is 0.

Width and arithmetic
- cnt counts 0..len-1 and compares with len-1 at full CNT_W; no wrap within a state.
- The layer counter saturates at its bounds.

Reset
- Asserting fsm_rst_n mid-sequence forces IDLE and the IDLE decode immediately; all counters clear.

Decomposition:
- Package train_ctrl_pkg:
  - state enum (IDLE/FEED/DRAIN/CLEAR) and phase encoding (FP/BP/WG);
  - inpref mode constants (MODE_FIRST_S2=00, MODE_FIRST_S1=01, MODE_CUT_S2=10, MODE_CUT_S1=11);
  - output-mode constants.
- One natural sub-module: phase_decode, a combinational (phase, state, stride_q) -> select/mode decode, reusable by the inference controller.

Test Plan:
1. phase_en=001, N=1, in_len=8, out_len=5, rst_len=1, stride=0 -> busy 14 cycles; in_en high 8, out_en high 5, pe_rst_n low 1; done one cycle; select1=1, en_cutting0=1, mode 01/000.
2. phase_en=111, N=2, in_len=2, out_len=1, rst_len=2 -> phase/layer_idx sequence FP0, FP1, BP1, BP0, WG1, WG0; 30 busy cycles; single done.
3. Same as 2 with stride=1 and stride toggled mid-FEED -> BP decode select1=0, en_cutting1=1, mode 10/100; toggle takes effect only at the next FEED entry.
4. abort on the 3rd DRAIN cycle of scenario 1 -> IDLE next cycle, done never asserted, in_en/out_en 0, pe_rst_n 0.
5. in_len=0, out_len=0, rst_len=0, FP only -> FEED 1, CLEAR 1, done; start with phase_en=000 -> done next cycle, busy stays 0.
6. fsm_rst_n asserted mid-FEED, and start pulsed while busy -> immediate IDLE decode; the start pulsed while busy has no effect.
